// File: rtl/text_writer.sv
// Character-stream front end for the tile screen buffer: consumes ASCII codes, tracks the
// cursor and drives the buffer write port, sweeping one tile per cycle for line/screen clears.
module text_writer #(
  parameter int unsigned H_TILES        = 128,
  parameter int unsigned V_TILES        = 48,
  parameter int unsigned ADDR_COL_WIDTH = 7,
  parameter int unsigned ADDR_ROW_WIDTH = 6,
  parameter int unsigned DATA_WIDTH     = 7
) (
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic                      char_valid_i,
  input  logic [DATA_WIDTH-1:0]     char_i,
  output logic                      char_ready_o,
  input  logic                      clear_i,
  output logic                      busy_o,
  output logic                      wr_en_o,
  output logic [ADDR_COL_WIDTH-1:0] col_w_o,
  output logic [ADDR_ROW_WIDTH-1:0] row_w_o,
  output logic [DATA_WIDTH-1:0]     din_o,
  output logic [ADDR_COL_WIDTH-1:0] cursor_col_o,
  output logic [ADDR_ROW_WIDTH-1:0] cursor_row_o
);

  typedef enum logic [1:0] {StIdle, StClrLine, StClrAll} state_e;

  localparam logic [ADDR_COL_WIDTH-1:0] ColLast = ADDR_COL_WIDTH'(H_TILES - 1);
  localparam logic [ADDR_ROW_WIDTH-1:0] RowLast = ADDR_ROW_WIDTH'(V_TILES - 1);
  localparam logic [ADDR_COL_WIDTH-1:0] ColOne  = ADDR_COL_WIDTH'(1);
  localparam logic [ADDR_ROW_WIDTH-1:0] RowOne  = ADDR_ROW_WIDTH'(1);

  localparam logic [DATA_WIDTH-1:0] ChBs    = DATA_WIDTH'(32'h08);
  localparam logic [DATA_WIDTH-1:0] ChLf    = DATA_WIDTH'(32'h0A);
  localparam logic [DATA_WIDTH-1:0] ChFf    = DATA_WIDTH'(32'h0C);
  localparam logic [DATA_WIDTH-1:0] ChCr    = DATA_WIDTH'(32'h0D);
  localparam logic [DATA_WIDTH-1:0] ChFirst = DATA_WIDTH'(32'h20);
  localparam logic [DATA_WIDTH-1:0] ChLast  = DATA_WIDTH'(32'h7E);

  state_e                    state_q, state_d;
  logic [ADDR_COL_WIDTH-1:0] cur_col_q, cur_col_d;
  logic [ADDR_ROW_WIDTH-1:0] cur_row_q, cur_row_d;
  logic [ADDR_COL_WIDTH-1:0] swp_col_q, swp_col_d;
  logic [ADDR_ROW_WIDTH-1:0] swp_row_q, swp_row_d;
  logic                      wr_en_q, wr_en_d;
  logic [ADDR_COL_WIDTH-1:0] col_w_q, col_w_d;
  logic [ADDR_ROW_WIDTH-1:0] row_w_q, row_w_d;
  logic [DATA_WIDTH-1:0]     din_q, din_d;

  logic                      accept;
  logic                      printable;
  logic                      row_adv;
  logic                      full_clr;
  logic [ADDR_ROW_WIDTH-1:0] row_next;

  assign char_ready_o = (state_q == StIdle) && !clear_i;
  assign accept       = char_valid_i && char_ready_o;
  assign printable    = (char_i >= ChFirst) && (char_i <= ChLast);
  // Explicit wrap: V_TILES need not be a power of two.
  assign row_next     = (cur_row_q == RowLast) ? '0 : cur_row_q + RowOne;

  assign busy_o       = (state_q != StIdle);
  assign wr_en_o      = wr_en_q;
  assign col_w_o      = col_w_q;
  assign row_w_o      = row_w_q;
  assign din_o        = din_q;
  assign cursor_col_o = cur_col_q;
  assign cursor_row_o = cur_row_q;

  always_comb begin
    state_d   = state_q;
    cur_col_d = cur_col_q;
    cur_row_d = cur_row_q;
    swp_col_d = swp_col_q;
    swp_row_d = swp_row_q;
    wr_en_d   = 1'b0;
    col_w_d   = col_w_q;
    row_w_d   = row_w_q;
    din_d     = din_q;
    row_adv   = 1'b0;
    full_clr  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear_i) begin
          full_clr = 1'b1;
        end else if (accept) begin
          if (printable) begin
            wr_en_d = 1'b1;
            col_w_d = cur_col_q;
            row_w_d = cur_row_q;
            din_d   = char_i;
            if (cur_col_q == ColLast) begin
              row_adv = 1'b1;
            end else begin
              cur_col_d = cur_col_q + ColOne;
            end
          end else begin
            case (char_i)
              ChLf: row_adv = 1'b1;
              ChCr: cur_col_d = '0;
              ChBs: begin
                if (cur_col_q != '0) begin
                  cur_col_d = cur_col_q - ColOne;
                  wr_en_d   = 1'b1;
                  col_w_d   = cur_col_q - ColOne;
                  row_w_d   = cur_row_q;
                  din_d     = '0;
                end
              end
              ChFf:    full_clr = 1'b1;
              default: ;
            endcase
          end
        end

        if (row_adv) begin
          cur_col_d = '0;
          cur_row_d = row_next;
          swp_col_d = '0;
          swp_row_d = row_next;
          state_d   = StClrLine;
        end
        if (full_clr) begin
          cur_col_d = '0;
          cur_row_d = '0;
          swp_col_d = '0;
          swp_row_d = '0;
          state_d   = StClrAll;
        end
      end

      StClrLine: begin
        wr_en_d = 1'b1;
        col_w_d = swp_col_q;
        row_w_d = swp_row_q;
        din_d   = '0;
        if (swp_col_q == ColLast) begin
          swp_col_d = '0;
          state_d   = StIdle;
        end else begin
          swp_col_d = swp_col_q + ColOne;
        end
      end

      StClrAll: begin
        wr_en_d = 1'b1;
        col_w_d = swp_col_q;
        row_w_d = swp_row_q;
        din_d   = '0;
        if (swp_col_q == ColLast) begin
          swp_col_d = '0;
          if (swp_row_q == RowLast) begin
            swp_row_d = '0;
            state_d   = StIdle;
          end else begin
            swp_row_d = swp_row_q + RowOne;
          end
        end else begin
          swp_col_d = swp_col_q + ColOne;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      cur_col_q <= '0;
      cur_row_q <= '0;
      swp_col_q <= '0;
      swp_row_q <= '0;
      wr_en_q   <= 1'b0;
      col_w_q   <= '0;
      row_w_q   <= '0;
      din_q     <= '0;
    end else begin
      state_q   <= state_d;
      cur_col_q <= cur_col_d;
      cur_row_q <= cur_row_d;
      swp_col_q <= swp_col_d;
      swp_row_q <= swp_row_d;
      wr_en_q   <= wr_en_d;
      col_w_q   <= col_w_d;
      row_w_q   <= row_w_d;
      din_q     <= din_d;
    end
  end

endmodule
